morse_recognize_char: RTL and testbench
=======================================

# morse_recognize_char

Translates one Morse character into a printable character code. Input is a packed vector of dits and dahs plus its element count. Sits between the dit/dah collector and the word decoder. Provides two outputs:
- a combinational code, consumed by the word decoder in the same cycle;
- a registered copy with an unknown-pattern flag, for display and debug paths.

## Interface
Parameters (shared constants from `defines.vh`):
- `MAX_MORSE_LEN`, 6: max elements per character; vector width of `dits_dahs`.
- `MORSE_LEN_W`, 3: width of `len`.
- `CHAR_W`, 6: width of a character code.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `aclr` in 1: reset, synchronous and active-high.
- `ce` in 1: clock enable for the registered outputs.
- `len` in `MORSE_LEN_W`: number of valid elements in `dits_dahs`.
- `dits_dahs` in `MAX_MORSE_LEN`: element values, 1 = dah, 0 = dit.
- `char` out `CHAR_W`: combinational decoded code.
- `char_q` out `CHAR_W`: registered decoded code.
- `unknown_q` out 1: registered flag, pattern not in the table.

## Operation
- Element order: `dits_dahs[len-1]` is the first element sent; `dits_dahs[0]` is the last. Bits at index ≥ `len` are ignored (don't-care).
- Code map:
  - 0–9: digits 0–9.
  - 10–35: letters A–Z.
  - 36: `CHAR_CODE__` (space).
  - 37: `CHAR_CODE_UNK`.
  - 38–43: punctuation (see Configuration).
- Letters and digits follow the international (ITU) Morse table. Examples: A = len 2, `01`; E = len 1, `0`; 0 = len 5, `11111`; 5 = len 5, `00000`.
- `len` = 0 → `CHAR_CODE__`. Represents an empty character, e.g. a gap.
- `len` > `MAX_MORSE_LEN`, or any pattern absent from the table → `CHAR_CODE_UNK`.
- `char` is purely combinational from `len`/`dits_dahs`, with no dependency on `clk`.
- `unknown_q` = 1 exactly when `char_q` == `CHAR_CODE_UNK`.
- Decoding is a full case on (`len`, masked pattern), so no latches and no X on any input combination.

## Timing
- `char`: 0-cycle latency.
- `char_q`/`unknown_q`: on the rising edge with `aclr`=0 and `ce`=1, load the decode of the current inputs, giving 1-cycle latency. With `ce`=0 they hold.
- Reset values: `char_q` = `CHAR_CODE__`, `unknown_q` = 0.
- `aclr` has priority over `ce`. Reset in mid-stream discards the pending registered value; `char` is unaffected.
- Inputs may change every cycle; there is no handshake.

## Configuration
- `MORSE_PUNCT_EN` defined: six punctuation patterns are recognised.
  - 38 `.` = `010101`
  - 39 `,` = `110011`
  - 40 `?` = `001100`
  - 41 `/` = `10010`
  - 42 `=` = `10001`
  - 43 `-` = `100001`
- `MORSE_PUNCT_EN` undefined: those patterns decode to `CHAR_CODE_UNK`. Codes 38–43 are never produced.

## Structure
- Shared package/header (`defines.vh`) holds:
  - `CHAR_W`, `MAX_MORSE_LEN`, `MORSE_LEN_W`;
  - every `CHAR_CODE_*` constant (digits, letters, `CHAR_CODE__`, `CHAR_CODE_UNK`, punctuation).
- The word decoder and display logic reuse these constants.
- One natural sub-module: `morse_code_lut`, the pure combinational table. The top adds the masking, range checks and output registers.

## Test plan
- `len`=2, `dits_dahs`=`xxxx01` → `char`=10 (A) in the same cycle. After a `ce` edge: `char_q`=10, `unknown_q`=0.
- `len`=5, `dits_dahs`=`x11111` → 0. `len`=5, `x00000` → 5. `len`=4, `0000` → 17 (H). Upper-bit garbage does not change any result.
- `len`=0 → 36. `len`=7 → 37. `len`=4, `1111` → 37 with `unknown_q`=1 after the edge.
- `len`=6, `010101` → 38 when `MORSE_PUNCT_EN` is defined, 37 when it is not.
- Load A, drop `ce`, change the inputs to E: `char`=14 but `char_q` stays 10. Assert `aclr` together with `ce`: next edge gives `char_q`=36, `unknown_q`=0.
- Exhaustive sweep of all `len`/`dits_dahs` combinations: `char` matches the golden ITU table, with no X values.

Source files
------------

// File: rtl/morse_recognize_char_pkg.sv
// Shared constants for the Morse character path: element/len/char widths and every
// character code used by the recognizer, the word decoder and the display logic.
// Also provides len_mask(), which keeps only the low `len` element bits.
// Optional feature macro: MORSE_PUNCT_EN (punctuation codes 38-43 are always defined
// here; only the recognizer decides whether they can be produced).
package morse_recognize_char_pkg;

  localparam int unsigned MAX_MORSE_LEN = 6;
  localparam int unsigned MORSE_LEN_W   = 3;
  localparam int unsigned CHAR_W        = 6;

  localparam logic [MORSE_LEN_W-1:0] MAX_LEN_VAL = MORSE_LEN_W'(MAX_MORSE_LEN);

  typedef logic [CHAR_W-1:0] char_code_t;

  // Digits
  localparam char_code_t CHAR_CODE_0 = 6'd0;
  localparam char_code_t CHAR_CODE_1 = 6'd1;
  localparam char_code_t CHAR_CODE_2 = 6'd2;
  localparam char_code_t CHAR_CODE_3 = 6'd3;
  localparam char_code_t CHAR_CODE_4 = 6'd4;
  localparam char_code_t CHAR_CODE_5 = 6'd5;
  localparam char_code_t CHAR_CODE_6 = 6'd6;
  localparam char_code_t CHAR_CODE_7 = 6'd7;
  localparam char_code_t CHAR_CODE_8 = 6'd8;
  localparam char_code_t CHAR_CODE_9 = 6'd9;
  // Letters
  localparam char_code_t CHAR_CODE_A = 6'd10;
  localparam char_code_t CHAR_CODE_B = 6'd11;
  localparam char_code_t CHAR_CODE_C = 6'd12;
  localparam char_code_t CHAR_CODE_D = 6'd13;
  localparam char_code_t CHAR_CODE_E = 6'd14;
  localparam char_code_t CHAR_CODE_F = 6'd15;
  localparam char_code_t CHAR_CODE_G = 6'd16;
  localparam char_code_t CHAR_CODE_H = 6'd17;
  localparam char_code_t CHAR_CODE_I = 6'd18;
  localparam char_code_t CHAR_CODE_J = 6'd19;
  localparam char_code_t CHAR_CODE_K = 6'd20;
  localparam char_code_t CHAR_CODE_L = 6'd21;
  localparam char_code_t CHAR_CODE_M = 6'd22;
  localparam char_code_t CHAR_CODE_N = 6'd23;
  localparam char_code_t CHAR_CODE_O = 6'd24;
  localparam char_code_t CHAR_CODE_P = 6'd25;
  localparam char_code_t CHAR_CODE_Q = 6'd26;
  localparam char_code_t CHAR_CODE_R = 6'd27;
  localparam char_code_t CHAR_CODE_S = 6'd28;
  localparam char_code_t CHAR_CODE_T = 6'd29;
  localparam char_code_t CHAR_CODE_U = 6'd30;
  localparam char_code_t CHAR_CODE_V = 6'd31;
  localparam char_code_t CHAR_CODE_W = 6'd32;
  localparam char_code_t CHAR_CODE_X = 6'd33;
  localparam char_code_t CHAR_CODE_Y = 6'd34;
  localparam char_code_t CHAR_CODE_Z = 6'd35;
  // Specials
  localparam char_code_t CHAR_CODE__   = 6'd36;
  localparam char_code_t CHAR_CODE_UNK = 6'd37;
  // Punctuation
  localparam char_code_t CHAR_CODE_PERIOD   = 6'd38;
  localparam char_code_t CHAR_CODE_COMMA    = 6'd39;
  localparam char_code_t CHAR_CODE_QUESTION = 6'd40;
  localparam char_code_t CHAR_CODE_SLASH    = 6'd41;
  localparam char_code_t CHAR_CODE_EQUALS   = 6'd42;
  localparam char_code_t CHAR_CODE_HYPHEN   = 6'd43;

  // Ones in bit positions [len-1:0]; one extra bit of headroom so len == MAX works.
  function automatic logic [MAX_MORSE_LEN-1:0] len_mask(input logic [MORSE_LEN_W-1:0] len);
    logic [MAX_MORSE_LEN:0] one;
    logic [MAX_MORSE_LEN:0] m;
    one = (MAX_MORSE_LEN + 1)'(1);
    m   = (one << len) - one;
    return m[MAX_MORSE_LEN-1:0];
  endfunction

endpackage

// File: rtl/morse_recognize_char_if.sv
// Bus between the dit/dah collector (master) and the character recognizer (slave).
//   ce        : clock enable for the registered outputs
//   len       : number of valid elements in dits_dahs
//   dits_dahs : elements, 1 = dah, 0 = dit, dits_dahs[len-1] sent first
//   char      : combinational decoded code
//   char_q    : registered decoded code
//   unknown_q : registered flag, char_q is CHAR_CODE_UNK
interface morse_recognize_char_if;
  import morse_recognize_char_pkg::*;

  logic                     ce;
  logic [MORSE_LEN_W-1:0]   len;
  logic [MAX_MORSE_LEN-1:0] dits_dahs;
  logic [CHAR_W-1:0]        char;
  logic [CHAR_W-1:0]        char_q;
  logic                     unknown_q;

  modport master (
    output ce, len, dits_dahs,
    input  char, char_q, unknown_q
  );

  modport slave (
    input  ce, len, dits_dahs,
    output char, char_q, unknown_q
  );

endinterface

// File: rtl/morse_recognize_char_lut.sv
// Morse code lookup table: pure combinational map from (len, masked pattern) to a
// character code following the ITU table. Unlisted keys give CHAR_CODE_UNK.
// Ports:
//   len     : element count
//   pattern : element bits, bits at index >= len must already be zero
//   code    : character code
// Macro: MORSE_PUNCT_EN adds the six punctuation patterns; without it they fall to
// CHAR_CODE_UNK.
module morse_recognize_char_lut
  import morse_recognize_char_pkg::*;
(
  input  logic [MORSE_LEN_W-1:0]   len,
  input  logic [MAX_MORSE_LEN-1:0] pattern,
  output logic [CHAR_W-1:0]        code
);

  logic [MORSE_LEN_W+MAX_MORSE_LEN-1:0] key;
  assign key = {len, pattern};

  always_comb begin
    code = CHAR_CODE_UNK;
    case (key)
      // len 1
      {3'd1, 6'b000000}: code = CHAR_CODE_E;
      {3'd1, 6'b000001}: code = CHAR_CODE_T;
      // len 2
      {3'd2, 6'b000000}: code = CHAR_CODE_I;
      {3'd2, 6'b000001}: code = CHAR_CODE_A;
      {3'd2, 6'b000010}: code = CHAR_CODE_N;
      {3'd2, 6'b000011}: code = CHAR_CODE_M;
      // len 3
      {3'd3, 6'b000000}: code = CHAR_CODE_S;
      {3'd3, 6'b000001}: code = CHAR_CODE_U;
      {3'd3, 6'b000010}: code = CHAR_CODE_R;
      {3'd3, 6'b000011}: code = CHAR_CODE_W;
      {3'd3, 6'b000100}: code = CHAR_CODE_D;
      {3'd3, 6'b000101}: code = CHAR_CODE_K;
      {3'd3, 6'b000110}: code = CHAR_CODE_G;
      {3'd3, 6'b000111}: code = CHAR_CODE_O;
      // len 4
      {3'd4, 6'b000000}: code = CHAR_CODE_H;
      {3'd4, 6'b000001}: code = CHAR_CODE_V;
      {3'd4, 6'b000010}: code = CHAR_CODE_F;
      {3'd4, 6'b000100}: code = CHAR_CODE_L;
      {3'd4, 6'b000110}: code = CHAR_CODE_P;
      {3'd4, 6'b000111}: code = CHAR_CODE_J;
      {3'd4, 6'b001000}: code = CHAR_CODE_B;
      {3'd4, 6'b001001}: code = CHAR_CODE_X;
      {3'd4, 6'b001010}: code = CHAR_CODE_C;
      {3'd4, 6'b001011}: code = CHAR_CODE_Y;
      {3'd4, 6'b001100}: code = CHAR_CODE_Z;
      {3'd4, 6'b001101}: code = CHAR_CODE_Q;
      // len 5: digits
      {3'd5, 6'b011111}: code = CHAR_CODE_0;
      {3'd5, 6'b001111}: code = CHAR_CODE_1;
      {3'd5, 6'b000111}: code = CHAR_CODE_2;
      {3'd5, 6'b000011}: code = CHAR_CODE_3;
      {3'd5, 6'b000001}: code = CHAR_CODE_4;
      {3'd5, 6'b000000}: code = CHAR_CODE_5;
      {3'd5, 6'b010000}: code = CHAR_CODE_6;
      {3'd5, 6'b011000}: code = CHAR_CODE_7;
      {3'd5, 6'b011100}: code = CHAR_CODE_8;
      {3'd5, 6'b011110}: code = CHAR_CODE_9;
`ifdef MORSE_PUNCT_EN
      {3'd5, 6'b010010}: code = CHAR_CODE_SLASH;
      {3'd5, 6'b010001}: code = CHAR_CODE_EQUALS;
      {3'd6, 6'b010101}: code = CHAR_CODE_PERIOD;
      {3'd6, 6'b110011}: code = CHAR_CODE_COMMA;
      {3'd6, 6'b001100}: code = CHAR_CODE_QUESTION;
      {3'd6, 6'b100001}: code = CHAR_CODE_HYPHEN;
`endif
      default:           code = CHAR_CODE_UNK;
    endcase
  end

endmodule

// File: rtl/morse_recognize_char.sv
// Morse character recognizer: masks the element vector to len bits, looks it up,
// handles the empty (len 0) and over-long cases, and registers the result.
// Ports:
//   clk  : clock, rising edge
//   aclr : synchronous active-high reset, priority over ce
//   bus  : slave side of morse_recognize_char_if (ce, len, dits_dahs in;
//          char, char_q, unknown_q out)
// Macro: MORSE_PUNCT_EN enables punctuation recognition (see the lut).
module morse_recognize_char
  import morse_recognize_char_pkg::*;
(
  input  logic                  clk,
  input  logic                  aclr,
  morse_recognize_char_if.slave bus
);

  logic [MAX_MORSE_LEN-1:0] pattern;
  logic [CHAR_W-1:0]        lut_code;
  logic [CHAR_W-1:0]        char_d;
  logic [CHAR_W-1:0]        char_reg_q;
  logic                     unknown_reg_q;

  // Elements beyond len are don't-care; clearing them keeps the lut keys unique.
  assign pattern = bus.dits_dahs & len_mask(bus.len);

  morse_recognize_char_lut u_lut (
    .len     (bus.len),
    .pattern (pattern),
    .code    (lut_code)
  );

  always_comb begin
    char_d = lut_code;
    if (bus.len == '0) begin
      char_d = CHAR_CODE__;
    end else if (bus.len > MAX_LEN_VAL) begin
      char_d = CHAR_CODE_UNK;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      char_reg_q    <= CHAR_CODE__;
      unknown_reg_q <= 1'b0;
    end else if (bus.ce) begin
      char_reg_q    <= char_d;
      unknown_reg_q <= (char_d == CHAR_CODE_UNK);
    end
  end

  assign bus.char      = char_d;
  assign bus.char_q    = char_reg_q;
  assign bus.unknown_q = unknown_reg_q;

endmodule

// File: tb/tb_morse_recognize_char.sv
// Bench for morse_recognize_char: directed literal checks, an exhaustive len/pattern
// sweep and a randomized run, all compared every cycle against a dot/dash string
// table model. Honours MORSE_PUNCT_EN the same way as the design.
module tb_morse_recognize_char;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  morse_recognize_char_if bif ();

  morse_recognize_char dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bif)
  );

  int total = 0;
  int bad   = 0;

  string tab [0:35] = '{
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
    "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--.."
  };
  string ptab [0:5] = '{".-.-.-", "--..--", "..--..", "-..-.", "-...-", "-....-"};

  function automatic int golden(input int l, input logic [5:0] d);
    string s;
    s = "";
    if (l == 0) return 36;
    if (l > 6) return 37;
    for (int i = l - 1; i >= 0; i--) begin
      if (d[i]) s = {s, "-"};
      else      s = {s, "."};
    end
    for (int k = 0; k < 36; k++) if (s == tab[k]) return k;
`ifdef MORSE_PUNCT_EN
    for (int k = 0; k < 6; k++) if (s == ptab[k]) return 38 + k;
`endif
    return 37;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (len=%0d dits_dahs=%b t=%0t)",
               name, got, want, bif.len, bif.dits_dahs, $time);
    end
  endtask

  // Registered-output model
  int exp_q     = 36;
  bit exp_valid = 1'b0;
  always @(posedge clk) begin
    if (aclr) begin
      exp_q     = 36;
      exp_valid = 1'b1;
    end else if (bif.ce) begin
      exp_q = golden(int'(bif.len), bif.dits_dahs);
    end
  end

  // Every-cycle compare
  always @(negedge clk) begin
    chk("char", {2'b00, bif.char}, 8'(golden(int'(bif.len), bif.dits_dahs)));
    if (exp_valid) begin
      chk("char_q", {2'b00, bif.char_q}, 8'(exp_q));
      chk("unknown_q", {7'd0, bif.unknown_q}, (exp_q == 37) ? 8'd1 : 8'd0);
    end
  end

  task automatic drive(input int l, input logic [5:0] d, input bit c, input bit r);
    @(posedge clk);
    #1;
    bif.len       = 3'(l);
    bif.dits_dahs = d;
    bif.ce        = c;
    aclr          = r;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    aclr          = 1'b1;
    bif.ce        = 1'b0;
    bif.len       = '0;
    bif.dits_dahs = '0;
    edge_wait();
    edge_wait();
    chk("rst_char_q", {2'b00, bif.char_q}, 8'd36);
    chk("rst_unknown_q", {7'd0, bif.unknown_q}, 8'd0);

    drive(2, 6'b101101, 1'b1, 1'b0);
    chk("A_comb", {2'b00, bif.char}, 8'd10);
    edge_wait();
    chk("A_q", {2'b00, bif.char_q}, 8'd10);
    chk("A_unk", {7'd0, bif.unknown_q}, 8'd0);

    drive(5, 6'b111111, 1'b1, 1'b0);
    chk("zero", {2'b00, bif.char}, 8'd0);
    drive(5, 6'b100000, 1'b1, 1'b0);
    chk("five", {2'b00, bif.char}, 8'd5);
    drive(4, 6'b110000, 1'b1, 1'b0);
    chk("H", {2'b00, bif.char}, 8'd17);
    drive(0, 6'b101010, 1'b1, 1'b0);
    chk("len0", {2'b00, bif.char}, 8'd36);
    drive(7, 6'b000001, 1'b1, 1'b0);
    chk("len7", {2'b00, bif.char}, 8'd37);
    drive(4, 6'b001111, 1'b1, 1'b0);
    chk("1111_comb", {2'b00, bif.char}, 8'd37);
    edge_wait();
    chk("1111_q", {2'b00, bif.char_q}, 8'd37);
    chk("1111_unk", {7'd0, bif.unknown_q}, 8'd1);

    drive(6, 6'b010101, 1'b1, 1'b0);
`ifdef MORSE_PUNCT_EN
    chk("period", {2'b00, bif.char}, 8'd38);
`else
    chk("period", {2'b00, bif.char}, 8'd37);
`endif

    drive(2, 6'b000001, 1'b1, 1'b0);
    drive(1, 6'b111110, 1'b0, 1'b0);
    chk("E_comb", {2'b00, bif.char}, 8'd14);
    edge_wait();
    chk("hold_q", {2'b00, bif.char_q}, 8'd10);
    drive(1, 6'b111110, 1'b1, 1'b1);
    edge_wait();
    chk("clr_q", {2'b00, bif.char_q}, 8'd36);
    chk("clr_unk", {7'd0, bif.unknown_q}, 8'd0);
    chk("clr_char", {2'b00, bif.char}, 8'd14);

    for (int l = 0; l < 8; l++) begin
      for (int d = 0; d < 64; d++) begin
        drive(l, 6'(d), 1'b1, 1'b0);
      end
    end

    for (int n = 0; n < 3000; n++) begin
      drive(int'($urandom_range(0, 7)), 6'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    end

    edge_wait();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
